// File: rtl/rf_bypass_sb_pkg.sv
// Shared register-file types and widths for the miniLA decode/writeback stages.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    localparam rf_data_t RF_ZERO = '0;

endpackage

// File: rtl/rf_bypass_sb_pend_cnt.sv
// Per-register pending-write counter: saturating at MAX_INFL, floor at zero,
// simultaneous inc/dec cancels, clr wins over everything.
module rf_pend_cnt #(
    parameter int unsigned MAX_INFL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nz,
    output logic full,
    output logic one
);

    localparam int unsigned CW = $clog2(MAX_INFL + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && cnt_q != CW'(MAX_INFL)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz   = (cnt_q != '0);
    assign full = (cnt_q == CW'(MAX_INFL));
    assign one  = (cnt_q == CW'(1));

endmodule

// File: rtl/rf_bypass_sb.sv
// Multi-read-port register file with writeback bypass and a per-register
// pending-write scoreboard used for RAW stall detection.
module rf_bypass_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned MAX_INFL = 3,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rf_we,
    input  logic [ADDR_W-1:0]       WR,
    input  logic [DATA_W-1:0]       WD,
    input  logic [NREAD*ADDR_W-1:0] rR,
    output logic [NREAD*DATA_W-1:0] RD,
    output logic [NREAD-1:0]        busy,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_wr,
    output logic                    iss_ready,
    input  logic                    flush
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam bit          BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  nz_w, full_w, one_w;
    logic              iss_acc;

    // r0 has no counter, so its status bits are tied low and it never stalls issue.
    assign nz_w[0]   = 1'b0;
    assign full_w[0] = 1'b0;
    assign one_w[0]  = 1'b0;

    assign iss_ready = !full_w[iss_wr];
    assign iss_acc   = iss_valid && iss_ready;

    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        rf_pend_cnt #(.MAX_INFL(MAX_INFL)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (iss_acc && (iss_wr == ADDR_W'(r))),
            .dec  (rf_we && (WR == ADDR_W'(r))),
            .clr  (flush),
            .nz   (nz_w[r]),
            .full (full_w[r]),
            .one  (one_w[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && WR != '0) begin
            regs_q[WR] <= WD;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = rR[k*ADDR_W +: ADDR_W];
        // Bypass is suppressed in reset so RD reads zero regardless of WD.
        assign hit  = BYPASS_EN && !rst && rf_we && (WR == addr) && (addr != '0);

        assign RD[k*DATA_W +: DATA_W] = (addr == '0) ? '0 :
                                        hit          ? WD : regs_q[addr];

        // A last pending write being forwarded right now no longer blocks the reader.
        assign busy[k] = !rst && nz_w[addr] && !(hit && one_w[addr]);
    end

endmodule
